// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with frame-aligned double buffering.
// Define SEG7_BLINK_EN to add the blink_mask port and per-digit blinking.
module seg7_scan_driver #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned GUARD        = 200,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [39:0] chars,
`ifdef SEG7_BLINK_EN
  input  logic [7:0]  blink_mask,
`endif
  output logic        ack,
  output logic        frame_start,
  output logic [7:0]  an,
  output logic [6:0]  digit
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  if (TICK_DIV < 2 || GUARD >= TICK_DIV || BLINK_FRAMES < 1) begin : g_bad_params
    $error("seg7_scan_driver: illegal TICK_DIV/GUARD/BLINK_FRAMES");
  end

  typedef enum logic {
    SCAN_GUARD,
    SCAN_DRIVE
  } state_t;

  // With no guard interval every slot starts directly in the drive phase.
  localparam state_t SLOT_ENTRY = (GUARD == 0) ? SCAN_DRIVE : SCAN_GUARD;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      slot_q;
  logic [7:0][4:0] active_q;
  logic [7:0][4:0] pending_q;
  logic            pend_valid_q;
  logic [7:0]      an_q;
  logic [6:0]      digit_q;
  logic            ack_q;
  logic            frame_start_q;

  logic            slot_end;
  logic            commit;
  logic [7:0]      an_d;
  logic [6:0]      digit_d;

`ifdef SEG7_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [7:0]    pend_mask_q;
  logic [7:0]    act_mask_q;
  logic [FW-1:0] fcnt_q;
  logic          blink_phase_q;
`endif

  function automatic logic [6:0] seg_glyph(input logic [4:0] code);
    case (code)
      5'h00:   seg_glyph = 7'h40;
      5'h01:   seg_glyph = 7'h79;
      5'h02:   seg_glyph = 7'h24;
      5'h03:   seg_glyph = 7'h30;
      5'h04:   seg_glyph = 7'h19;
      5'h05:   seg_glyph = 7'h12;
      5'h06:   seg_glyph = 7'h02;
      5'h07:   seg_glyph = 7'h78;
      5'h08:   seg_glyph = 7'h00;
      5'h09:   seg_glyph = 7'h10;
      5'h0A:   seg_glyph = 7'h08;
      5'h0B:   seg_glyph = 7'h03;
      5'h0C:   seg_glyph = 7'h46;
      5'h0D:   seg_glyph = 7'h21;
      5'h0E:   seg_glyph = 7'h06;
      5'h0F:   seg_glyph = 7'h0E;
      5'h11:   seg_glyph = 7'h3F;
      5'h12:   seg_glyph = 7'h03;
      5'h13:   seg_glyph = 7'h46;
      5'h14:   seg_glyph = 7'h63;
      5'h15:   seg_glyph = 7'h47;
      5'h16:   seg_glyph = 7'h12;
      5'h17:   seg_glyph = 7'h23;
      5'h18:   seg_glyph = 7'h0C;
      5'h19:   seg_glyph = 7'h2F;
      default: seg_glyph = 7'h7F;
    endcase
  endfunction

  assign slot_end = (cnt_q == CNT_LAST);
  assign commit   = slot_end && (slot_q == 3'd7);

  always_comb begin
    an_d    = (state_q == SCAN_GUARD) ? 8'hFF : ~(8'h01 << slot_q);
    digit_d = seg_glyph(active_q[slot_q]);
`ifdef SEG7_BLINK_EN
    if (blink_phase_q && act_mask_q[slot_q]) begin
      digit_d = 7'h7F;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= SLOT_ENTRY;
      cnt_q         <= '0;
      slot_q        <= '0;
      active_q      <= {8{5'h10}};
      pending_q     <= {8{5'h10}};
      pend_valid_q  <= 1'b0;
      an_q          <= '1;
      digit_q       <= '1;
      ack_q         <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef SEG7_BLINK_EN
      pend_mask_q   <= '0;
      act_mask_q    <= '0;
      fcnt_q        <= '0;
      blink_phase_q <= 1'b0;
`endif
    end else begin
      frame_start_q <= (slot_q == 3'd0) && (cnt_q == '0);
      ack_q         <= commit && pend_valid_q;
      an_q          <= an_d;
      if (cnt_q == '0) begin
        digit_q <= digit_d;
      end

      if (slot_end) begin
        cnt_q   <= '0;
        slot_q  <= slot_q + 3'd1;
        state_q <= SLOT_ENTRY;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        if (state_q == SCAN_GUARD && (cnt_q + CW'(1)) == GUARD_C) begin
          state_q <= SCAN_DRIVE;
        end
      end

      // A load landing in the commit cycle stays pending for the next frame.
      if (commit && pend_valid_q) begin
        active_q <= pending_q;
`ifdef SEG7_BLINK_EN
        act_mask_q <= pend_mask_q;
`endif
      end
      if (load) begin
        pending_q    <= chars;
        pend_valid_q <= 1'b1;
`ifdef SEG7_BLINK_EN
        pend_mask_q  <= blink_mask;
`endif
      end else if (commit) begin
        pend_valid_q <= 1'b0;
      end

`ifdef SEG7_BLINK_EN
      // Phase is updated at frame end so it is already valid for slot 0 of the new frame.
      if (commit) begin
        if (fcnt_q == FRAME_LAST) begin
          fcnt_q        <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          fcnt_q <= fcnt_q + FW'(1);
        end
      end
`endif
    end
  end

  assign an          = an_q;
  assign digit       = digit_q;
  assign ack         = ack_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (TICK_DIV=4, GUARD=1, BLINK_FRAMES=2).
module tb_seg7_scan_driver;

  logic        clock;
  logic        reset;
  logic        load;
  logic [39:0] chars;
  logic [7:0]  blink_mask;
  logic        ack;
  logic        frame_start;
  logic [7:0]  an;
  logic [6:0]  digit;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan_driver #(
    .TICK_DIV    (4),
    .GUARD       (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .chars      (chars),
`ifdef SEG7_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .ack        (ack),
    .frame_start(frame_start),
    .an         (an),
    .digit      (digit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Leaves the bench at the negedge where frame_start is high (slot 0 guard cycle).
  task automatic wait_fs(output int cycles);
    bit ok;
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      cycles++;
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_frame_start: no frame_start within %0d cycles, required one", cycles);
    end
  endtask

  task automatic test_reset;
    int cyc;
    reset = 1'b1;
    load  = 1'b0;
    chars = '0;
    blink_mask = '0;
    #1;
    n_tests++;
    if (an !== 8'hFF || digit !== 7'h7F || ack !== 1'b0 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: an=%h digit=%h ack=%b fs=%b, required FF 7F 0 0", an, digit, ack, frame_start);
    end
    step(3);
    n_tests++;
    if (an !== 8'hFF || digit !== 7'h7F || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: an=%h digit=%h fs=%b, required FF 7F 0", an, digit, frame_start);
    end
    reset = 1'b0;
    wait_fs(cyc);
    n_tests++;
    if (cyc != 1 || an !== 8'hFF || digit !== 7'h7F) begin
      n_fail++;
      $display("FAIL first_frame: cycles=%0d an=%h digit=%h, required 1 FF 7F", cyc, an, digit);
    end
  endtask

  task automatic test_load_commit;
    int cyc;
    int acks;
    int ack_p;
    logic [7:0] exp_an;
    logic [6:0] exp_g [8];
    exp_g = '{7'h79, 7'h30, 7'h7F, 7'h12, 7'h47, 7'h47, 7'h63, 7'h03};
    wait_fs(cyc);
    step(9);
    load  = 1'b1;
    chars = {5'h12, 5'h14, 5'h15, 5'h15, 5'h16, 5'h10, 5'h03, 5'h01};
    step(1);
    load  = 1'b0;
    acks  = 0;
    ack_p = -1;
    for (int p = 10; p < 32; p++) begin
      n_tests++;
      if (digit !== 7'h7F) begin
        n_fail++;
        $display("FAIL load_no_tear p=%0d: digit=%h, required 7F", p, digit);
      end
      if (ack === 1'b1) begin
        acks++;
        ack_p = p;
      end
      step(1);
    end
    n_tests++;
    if (acks != 1 || ack_p != 31) begin
      n_fail++;
      $display("FAIL load_ack: count=%0d at p=%0d, required 1 at p=31", acks, ack_p);
    end
    for (int p = 0; p < 32; p++) begin
      exp_an = (p % 4 == 0) ? 8'hFF : ~(8'h01 << (p / 4));
      n_tests++;
      if (an !== exp_an || digit !== exp_g[p / 4] || frame_start !== (p == 0) || ack !== 1'b0) begin
        n_fail++;
        $display("FAIL load_display p=%0d: an=%h digit=%h fs=%b ack=%b, required %h %h %b 0",
                 p, an, digit, frame_start, ack, exp_an, exp_g[p / 4], (p == 0));
      end
      if (p < 31) step(1);
    end
  endtask

  task automatic test_last_load_wins;
    int cyc;
    int acks;
    wait_fs(cyc);
    step(5);
    load  = 1'b1;
    chars = {8{5'h0A}};
    step(1);
    load  = 1'b0;
    step(14);
    load  = 1'b1;
    chars = {8{5'h0B}};
    step(1);
    load  = 1'b0;
    acks  = 0;
    for (int p = 21; p < 32; p++) begin
      if (ack === 1'b1) acks++;
      step(1);
    end
    for (int p = 0; p < 32; p++) begin
      n_tests++;
      if (digit !== 7'h03) begin
        n_fail++;
        $display("FAIL last_load_digit p=%0d: digit=%h, required 03", p, digit);
      end
      if (ack === 1'b1) acks++;
      if (p < 31) step(1);
    end
    n_tests++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL last_load_ack: count=%0d, required 1", acks);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    wait_fs(cyc);
    step(10);
    load  = 1'b1;
    chars = {8{5'h05}};
    step(1);
    load  = 1'b0;
    step(19);
    load  = 1'b1;
    chars = {8{5'h06}};
    step(1);
    load  = 1'b0;
    n_tests++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_cycle_ack1: ack=%b, required 1", ack);
    end
    step(1);
    for (int p = 0; p < 32; p++) begin
      n_tests++;
      if (digit !== 7'h12 || ack !== (p == 31)) begin
        n_fail++;
        $display("FAIL commit_cycle_fives p=%0d: digit=%h ack=%b, required 12 %b", p, digit, ack, (p == 31));
      end
      step(1);
    end
    for (int p = 0; p < 32; p++) begin
      n_tests++;
      if (digit !== 7'h02 || ack !== 1'b0) begin
        n_fail++;
        $display("FAIL commit_cycle_sixes p=%0d: digit=%h ack=%b, required 02 0", p, digit, ack);
      end
      if (p < 31) step(1);
    end
  endtask

  task automatic test_undefined_code;
    int cyc;
    logic [7:0] exp_an;
    logic [6:0] exp_d;
    wait_fs(cyc);
    step(2);
    load  = 1'b1;
    chars = {5'h11, 5'h11, 5'h11, 5'h1C, 5'h11, 5'h11, 5'h11, 5'h11};
    step(1);
    load  = 1'b0;
    wait_fs(cyc);
    for (int p = 0; p < 32; p++) begin
      exp_an = (p % 4 == 0) ? 8'hFF : ~(8'h01 << (p / 4));
      exp_d  = (p / 4 == 4) ? 7'h7F : 7'h3F;
      n_tests++;
      if (an !== exp_an || digit !== exp_d) begin
        n_fail++;
        $display("FAIL undefined_code p=%0d: an=%h digit=%h, required %h %h", p, an, digit, exp_an, exp_d);
      end
      if (p < 31) step(1);
    end
  endtask

  task automatic test_mid_reset;
    int cyc;
    wait_fs(cyc);
    step(2);
    load  = 1'b1;
    chars = {8{5'h07}};
    step(1);
    load  = 1'b0;
    step(10);
    n_tests++;
    if (an !== 8'hF7 || digit !== 7'h3F) begin
      n_fail++;
      $display("FAIL pre_reset_slot3: an=%h digit=%h, required F7 3F", an, digit);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (an !== 8'hFF || digit !== 7'h7F || ack !== 1'b0 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: an=%h digit=%h ack=%b fs=%b, required FF 7F 0 0", an, digit, ack, frame_start);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    wait_fs(cyc);
    n_tests++;
    if (cyc != 1) begin
      n_fail++;
      $display("FAIL reset_restart: frame_start after %0d cycles, required 1", cyc);
    end
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 32; p++) begin
        n_tests++;
        if (digit !== 7'h7F || ack !== 1'b0 || frame_start !== (p == 0)) begin
          n_fail++;
          $display("FAIL reset_blank f=%0d p=%0d: digit=%h ack=%b fs=%b, required 7F 0 %b",
                   f, p, digit, ack, frame_start, (p == 0));
        end
        step(1);
      end
    end
    n_tests++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_period: fs=%b after 32 cycles, required 1", frame_start);
    end
  endtask

`ifdef SEG7_BLINK_EN
  task automatic test_blink;
    int cyc;
    logic [6:0] exp0;
    step(1);
    #2;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    wait_fs(cyc);
    load       = 1'b1;
    chars      = {8{5'h08}};
    blink_mask = 8'h01;
    step(1);
    load       = 1'b0;
    blink_mask = 8'h00;
    for (int f = 1; f < 8; f++) begin
      wait_fs(cyc);
      exp0 = (f == 2 || f == 3 || f == 6 || f == 7) ? 7'h7F : 7'h00;
      n_tests++;
      if (digit !== exp0) begin
        n_fail++;
        $display("FAIL blink_d0 f=%0d: digit=%h, required %h", f, digit, exp0);
      end
      step(1);
      n_tests++;
      if (an !== 8'hFE) begin
        n_fail++;
        $display("FAIL blink_anode f=%0d: an=%h, required FE", f, an);
      end
      step(3);
      n_tests++;
      if (digit !== 7'h00) begin
        n_fail++;
        $display("FAIL blink_d1 f=%0d: digit=%h, required 00", f, digit);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_commit();
    test_last_load_wins();
    test_back_to_back();
    test_undefined_code();
    test_mid_reset();
`ifdef SEG7_BLINK_EN
    test_blink();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
